// File: rtl/vblank_update_scheduler.sv
// Grants exclusive game-state update slots to requesters, round-robin, inside the
// VGA vertical blanking interval. States: IDLE wait for frame | SCAN pick next | GRANT slot owned.
module vblank_update_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int ACTIVE_ROWS      = 480,
  parameter int MAX_GRANT_CYCLES = 4096
) (
  input  logic               VGA_clk,
  input  logic               resetn,
  input  logic [9:0]         xCount,
  input  logic [9:0]         yCount,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               vblank,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(MAX_GRANT_CYCLES);

  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(MAX_GRANT_CYCLES - 1);
  localparam logic [9:0]         ROW_VB   = 10'(ACTIVE_ROWS);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_vblank;
  logic               r_frame_start;
  logic [15:0]        r_frame_count;
  logic               r_overrun;
  logic               r_timeout;
  logic               r_armed;

  logic               w_vb_next;
  logic               w_fs_next;
  logic               w_vb_fall;
  logic               w_abort;
  logic               w_done_g;
  logic               w_wd_exp;
  logic [IDX_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_unused;

  assign w_unused  = ^xCount;
  assign w_vb_next = (yCount >= ROW_VB);
  // r_armed blocks a frame start when reset releases while already inside vblank
  assign w_fs_next = w_vb_next & ~r_vblank & r_armed;
  assign w_vb_fall = ~w_vb_next & r_vblank;
  assign w_abort   = w_vb_fall && (r_state == ST_SCAN || r_state == ST_GRANT)
                     && (r_pending != '0);
  assign w_done_g  = |(done & r_grant);
  assign w_wd_exp  = (r_wd_cnt == WD_LAST);
  assign w_pick_oh = ONE << w_pick;
  assign w_next_ptr = (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + 1'b1;

  // Walk downward so the closest set bit at or after r_rr_ptr is written last
  always_comb begin
    w_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (|(r_pending & (ONE << ((int'(r_rr_ptr) + k) % NUM_REQ))))
        w_pick = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 16'd0;
      r_armed       <= 1'b0;
    end else begin
      r_vblank      <= w_vb_next;
      r_frame_start <= w_fs_next;
      r_armed       <= r_armed | ~w_vb_next;
      if (w_fs_next)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn)
      r_overrun <= 1'b0;
    else
      r_overrun <= w_abort | (r_overrun & ~overrun_clr);
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_abort) begin
        // the interrupted requester goes first next frame
        r_grant   <= '0;
        r_pending <= '0;
        r_state   <= ST_IDLE;
        r_rr_ptr  <= (r_state == ST_GRANT) ? r_gnt_idx : w_pick;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_fs_next) begin
              r_pending <= req;
              r_state   <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (r_pending == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_grant   <= w_pick_oh;
              r_gnt_idx <= w_pick;
              r_wd_cnt  <= '0;
              r_state   <= ST_GRANT;
            end
          end
          ST_GRANT: begin
            if (w_done_g || w_wd_exp) begin
              r_grant   <= '0;
              r_pending <= r_pending & ~r_grant;
              r_rr_ptr  <= w_next_ptr;
              r_timeout <= ~w_done_g;
              r_state   <= ST_SCAN;
            end else begin
              r_wd_cnt <= r_wd_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign grant       = r_grant;
  assign vblank      = r_vblank;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: short-watchdog instance for grant/timeout
// behaviour, long-watchdog instance for vblank-end overrun behaviour.
module tb_vblank_update_scheduler;

  logic       VGA_clk;
  logic       resetn;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic [3:0] req;
  logic [3:0] done;
  logic       overrun_clr;

  logic [3:0]  grant_s, grant_l;
  logic        vblank_s, vblank_l;
  logic        frame_start_s, frame_start_l;
  logic [15:0] frame_count_s, frame_count_l;
  logic        overrun_s, overrun_l;
  logic        timeout_s, timeout_l;

  vblank_update_scheduler #(.NUM_REQ(4), .ACTIVE_ROWS(480), .MAX_GRANT_CYCLES(16)) u_dut_s (
    .VGA_clk(VGA_clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
    .req(req), .done(done), .grant(grant_s), .vblank(vblank_s),
    .frame_start(frame_start_s), .frame_count(frame_count_s), .overrun(overrun_s),
    .overrun_clr(overrun_clr), .timeout(timeout_s)
  );

  vblank_update_scheduler #(.NUM_REQ(4), .ACTIVE_ROWS(480), .MAX_GRANT_CYCLES(65535)) u_dut_l (
    .VGA_clk(VGA_clk), .resetn(resetn), .xCount(xCount), .yCount(yCount),
    .req(req), .done(done), .grant(grant_l), .vblank(vblank_l),
    .frame_start(frame_start_l), .frame_count(frame_count_l), .overrun(overrun_l),
    .overrun_clr(overrun_clr), .timeout(timeout_l)
  );

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  int         n_chk = 0;
  int         n_bad = 0;
  bit         auto_y = 1'b1;
  logic [9:0] y_smp;
  int         lat[4];
  int         clr_at = -1;

  logic [3:0] gr_log[8];
  int         gr_cyc[8];
  int         dr_cyc[8];
  int         n_gr;
  int         to_n;
  int         to_cyc;
  logic       ov_hist[64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_s();
    return {8'd0, frame_count_s, grant_s, vblank_s, frame_start_s, overrun_s, timeout_s};
  endfunction

  function automatic logic [31:0] outs_l();
    return {8'd0, frame_count_l, grant_l, vblank_l, frame_start_l, overrun_l, timeout_l};
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge VGA_clk);
    y_smp = yCount;
    #1;
    if (auto_y) yCount = (yCount == 10'd525) ? 10'd0 : yCount + 10'd1;
  endtask

  task automatic run_until(input logic [9:0] y);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      step();
      if (y_smp == y) hit = 1'b1;
    end
    if (!hit) check_eq("sync_timeout", 32'(y_smp), 32'(y));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Runs one vblank from the frame_start edge; c counts edges after it.
  task automatic serve_frame(input logic [3:0] rq, input bit use_long);
    logic [3:0] g, pg;
    int age, ix;
    n_gr = 0; to_n = 0; to_cyc = -1; pg = 4'd0; age = 0;
    for (int k = 0; k < 8; k++) begin gr_log[k] = 4'd0; gr_cyc[k] = -1; dr_cyc[k] = -1; end
    req = rq;
    run_until(10'd480);
    for (int c = 1; c <= 60; c++) begin
      overrun_clr = (c == clr_at);
      step();
      g = use_long ? grant_l : grant_s;
      ov_hist[c] = use_long ? overrun_l : overrun_s;
      if (use_long ? timeout_l : timeout_s) begin
        to_n++;
        if (to_cyc < 0) to_cyc = c;
      end
      if (g != pg && pg != 4'd0 && n_gr > 0) dr_cyc[n_gr-1] = c;
      if (g != 4'd0 && g != pg) begin
        if (n_gr < 8) begin gr_log[n_gr] = g; gr_cyc[n_gr] = c; n_gr++; end
        age = 0;
      end else if (g != 4'd0) begin
        age++;
      end
      ix = oh_idx(g);
      done = (g != 4'd0 && lat[ix] != 0 && age == lat[ix] - 1) ? g : 4'd0;
      pg = g;
    end
    done = 4'd0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    int fs_n, fs_y, fc_at, gr_or;
    resetn = 1'b0; xCount = 10'd0; yCount = 10'd0; req = 4'd0; done = 4'd0;
    overrun_clr = 1'b0;

    // 1: reset and one idle frame
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("rst_outs_s", outs_s(), 0);
      check_eq("rst_outs_l", outs_l(), 0);
    end
    resetn = 1'b1;
    fs_n = 0; fs_y = -1; fc_at = -1; gr_or = 0;
    for (int i = 0; i < 526; i++) begin
      step();
      if (frame_start_s) begin fs_n++; fs_y = int'(y_smp); fc_at = int'(frame_count_s); end
      gr_or = gr_or | int'(grant_s);
    end
    check_eq("idle_fs_count", fs_n, 1);
    check_eq("idle_fs_row", fs_y, 480);
    check_eq("idle_frame_count", fc_at, 1);
    check_eq("idle_no_grant", gr_or, 0);

    // 2: round-robin over two frames
    lat = '{10, 10, 10, 10};
    for (int f = 0; f < 2; f++) begin
      serve_frame(4'b1011, 1'b0);
      check_eq("rr_ngrants", n_gr, 3);
      check_eq("rr_g0", 32'(gr_log[0]), 'b0001);
      check_eq("rr_g1", 32'(gr_log[1]), 'b0010);
      check_eq("rr_g2", 32'(gr_log[2]), 'b1000);
      check_eq("rr_c0", gr_cyc[0], 1);
      check_eq("rr_c1", gr_cyc[1], 12);
      check_eq("rr_c2", gr_cyc[2], 23);
      check_eq("rr_d0", dr_cyc[0], 11);
      check_eq("rr_d2", dr_cyc[2], 33);
      check_eq("rr_no_timeout", to_n, 0);
      check_eq("rr_no_overrun", 32'(ov_hist[50]), 0);
    end

    // 3: watchdog on the second grantee
    lat = '{3, 0, 0, 0};
    serve_frame(4'b0011, 1'b0);
    check_eq("wd_ngrants", n_gr, 2);
    check_eq("wd_g1", 32'(gr_log[1]), 'b0010);
    check_eq("wd_c1", gr_cyc[1], 5);
    check_eq("wd_timeout_cyc", to_cyc, 21);
    check_eq("wd_timeout_width", to_n, 1);
    check_eq("wd_drop_cyc", dr_cyc[1], 21);
    check_eq("wd_no_overrun", 32'(ov_hist[50]), 0);

    // 4: overrun on the long-watchdog instance
    do_reset();
    lat = '{0, 0, 0, 0};
    serve_frame(4'b0001, 1'b1);
    check_eq("ov_g0", 32'(gr_log[0]), 'b0001);
    check_eq("ov_c0", gr_cyc[0], 1);
    check_eq("ov_drop_at_wrap", dr_cyc[0], 46);
    check_eq("ov_before_end", 32'(ov_hist[45]), 0);
    check_eq("ov_set", 32'(ov_hist[46]), 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check_eq("ov_clr", 32'(overrun_l), 0);
    lat = '{3, 3, 0, 0};
    serve_frame(4'b0011, 1'b1);
    check_eq("ov_next_first", 32'(gr_log[0]), 'b0001);
    check_eq("ov_next_second", 32'(gr_log[1]), 'b0010);
    check_eq("ov_next_clean", 32'(ov_hist[50]), 0);
    lat = '{0, 0, 0, 0};
    clr_at = 46;
    serve_frame(4'b0010, 1'b1);
    clr_at = -1;
    check_eq("ov_hold_g", 32'(gr_log[0]), 'b0010);
    check_eq("ov_pre_setwin", 32'(ov_hist[45]), 0);
    check_eq("ov_set_wins", 32'(ov_hist[46]), 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check_eq("ov_clr2", 32'(overrun_l), 0);
    lat = '{3, 3, 0, 0};
    serve_frame(4'b0011, 1'b1);
    check_eq("ov_abort_first", 32'(gr_log[0]), 'b0010);
    check_eq("ov_abort_second", 32'(gr_log[1]), 'b0001);

    // 6: reset in the middle of a grant
    do_reset();
    req = 4'b0101;
    run_until(10'd480);
    step();
    check_eq("mr_g0", 32'(grant_s), 'b0001);
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    check_eq("mr_pre_rst", 32'(grant_s), 'b0100);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mr_async_grant", 32'(grant_s), 0);
    check_eq("mr_async_outs", outs_s(), 0);
    step(); step(); step();
    check_eq("mr_held_outs", outs_s(), 0);
    resetn = 1'b1;
    fs_n = 0; gr_or = 0;
    for (int i = 0; i < 600 && y_smp != 10'd479; i++) begin
      step();
      if (frame_start_s) fs_n++;
      gr_or = gr_or | int'(grant_s) | (int'(overrun_s) << 4);
    end
    check_eq("mr_sync_row", 32'(y_smp), 479);
    check_eq("mr_no_fs", fs_n, 0);
    check_eq("mr_no_grant", gr_or, 0);
    step();
    check_eq("mr_fs", 32'(frame_start_s), 1);
    check_eq("mr_fc", 32'(frame_count_s), 1);
    step();
    check_eq("mr_rr_restart", 32'(grant_s), 'b0001);
    req = 4'b0000;

    // 5: frame counter pacing and wrap with two-cycle frames
    run_until(10'd10);
    do_reset();
    auto_y = 1'b0;
    yCount = 10'd0;
    step(); step();
    for (int f = 1; f <= 20; f++) begin
      yCount = 10'd480;
      step();
      check_eq("fc_fs_hi", 32'(frame_start_s), 1);
      check_eq("fc_val", 32'(frame_count_s), f);
      yCount = 10'd0;
      step();
      check_eq("fc_fs_lo", 32'(frame_start_s), 0);
    end
    force u_dut_s.r_frame_count = 16'hFFFD;
    step();
    release u_dut_s.r_frame_count;
    step();
    check_eq("fc_preload", 32'(frame_count_s), 'hFFFD);
    for (int f = 0; f < 4; f++) begin
      yCount = 10'd480;
      step();
      check_eq("fcw_fs_hi", 32'(frame_start_s), 1);
      check_eq("fcw_val", 32'(frame_count_s), (f + 'hFFFE) & 'hFFFF);
      yCount = 10'd0;
      step();
      check_eq("fcw_fs_lo", 32'(frame_start_s), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
